// File: rtl/control_unit_mc2.sv
// control_unit_mc2: multicycle RV32I(+M) control FSM with memory wait timeout, traps and retired-instruction counter
// Ports: i_clk/i_rst_n (async active-low reset); i_opcode/i_funct3/i_funct7 instruction fields;
//   i_zero/i_less_than/i_signed_less_than ALU flags; i_mem_ready, i_md_done, i_trap_ack handshakes;
//   o_pc_write/o_reg_write/o_mem_write/o_ir_write enables; o_mem_req/o_adr_src memory control;
//   o_alu_src_a/o_alu_src_b/o_result_src/o_alu_control/o_imm_src datapath selects;
//   o_md_start pulse; o_trap/o_trap_cause trap status; o_retired_count instruction counter.
module control_unit_mc2 #(
  parameter bit ENABLE_MULDIV = 1'b1,
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic             i_zero,
  input  logic             i_less_than,
  input  logic             i_signed_less_than,
  input  logic             i_mem_ready,
  input  logic             i_md_done,
  input  logic             i_trap_ack,
  output logic             o_pc_write,
  output logic             o_reg_write,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_mem_req,
  output logic             o_adr_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_result_src,
  output logic [3:0]       o_alu_control,
  output logic [2:0]       o_imm_src,
  output logic             o_md_start,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retired_count
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_EXEC_I,
    S_MULDIV, S_ALU_WB, S_JAL, S_JALR, S_BRANCH, S_LUI, S_AUIPC, S_TRAP
  } state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_wait;
  logic [1:0]       r_cause;
  logic             r_from_md;
  logic [CNT_W-1:0] r_retired;
  logic             w_timeout, w_take, w_f3_bad;
  logic [3:0]       w_alu_op;
  // last allowed wait cycle without mem_ready; a ready in that same cycle still completes
  assign w_timeout = r_wait == 8'(MEM_TIMEOUT - 1) && !i_mem_ready;
  // funct3[2] picks lt/slt compare vs equality, funct3[0] inverts the condition
  assign w_take = i_funct3[2] ? ((i_funct3[1] ? i_less_than : i_signed_less_than) ^ i_funct3[0])
                              : (!i_funct3[1] && (i_zero ^ i_funct3[0]));
  assign w_f3_bad = i_funct3[2:1] == 2'b01;
  assign w_alu_op = i_funct3 == 3'b000 ? ((r_state == S_EXEC_R && i_funct7[5]) ? 4'b0001 : 4'b0000)
                  : i_funct3 == 3'b001 ? 4'b1000
                  : i_funct3 == 3'b010 ? 4'b0101
                  : i_funct3 == 3'b011 ? 4'b1001
                  : i_funct3 == 3'b100 ? 4'b0100
                  : i_funct3 == 3'b101 ? (i_funct7[5] ? 4'b0111 : 4'b0110)
                  : i_funct3 == 3'b110 ? 4'b0011 : 4'b0010;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     w_next = i_mem_ready ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
      S_DECODE:    w_next = (i_opcode == 7'b0000011 || i_opcode == 7'b0100011) ? S_MEM_ADR
                          : i_opcode == 7'b0110011 ? (i_funct7 != 7'b0000001 ? S_EXEC_R
                                                     : ENABLE_MULDIV ? S_MULDIV : S_TRAP)
                          : i_opcode == 7'b0010011 ? S_EXEC_I
                          : i_opcode == 7'b1101111 ? S_JAL
                          : i_opcode == 7'b1100111 ? S_JALR
                          : i_opcode == 7'b1100011 ? S_BRANCH
                          : i_opcode == 7'b0110111 ? S_LUI
                          : i_opcode == 7'b0010111 ? S_AUIPC : S_TRAP;
      S_MEM_ADR:   w_next = i_opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = i_mem_ready ? S_MEM_WB : w_timeout ? S_TRAP : S_MEM_READ;
      S_MEM_WRITE: w_next = i_mem_ready ? S_FETCH : w_timeout ? S_TRAP : S_MEM_WRITE;
      S_MULDIV:    w_next = i_md_done ? S_ALU_WB : S_MULDIV;
      S_BRANCH:    w_next = w_f3_bad ? S_TRAP : S_FETCH;
      S_TRAP:      w_next = i_trap_ack ? S_FETCH : S_TRAP;
      S_MEM_WB, S_ALU_WB: w_next = S_FETCH;
      default:     w_next = S_ALU_WB;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_cause   <= 2'b00;
      r_from_md <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_next != r_state ? '0 : r_wait + 8'(~&r_wait);
      r_from_md <= r_state == S_MULDIV;
      r_cause   <= w_next != S_TRAP ? 2'b00
                 : r_state != S_TRAP ? ((r_state == S_DECODE || r_state == S_BRANCH) ? 2'b01 : 2'b10)
                 : r_cause;
      if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_TRAP)
        r_retired <= r_retired + CNT_W'(1);
    end
  end
  // outputs are decoded from the state (plus the Mealy handshakes) and forced low during reset
  always_comb begin
    o_pc_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_mem_req     = 1'b0;
    o_adr_src     = 1'b0;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_result_src  = 2'b00;
    o_alu_control = 4'b0000;
    o_imm_src     = 3'b000;
    o_md_start    = 1'b0;
    o_trap        = 1'b0;
    if (i_rst_n) begin
      o_imm_src = i_opcode == 7'b0100011 ? 3'b001
                : i_opcode == 7'b1100011 ? 3'b010
                : i_opcode == 7'b1101111 ? 3'b011
                : (i_opcode == 7'b0110111 || i_opcode == 7'b0010111) ? 3'b100 : 3'b000;
      case (r_state)
        S_FETCH: begin
          o_mem_req    = 1'b1;
          o_alu_src_a  = 2'b01;
          o_alu_src_b  = 2'b10;
          o_result_src = 2'b10;
          o_ir_write   = i_mem_ready;
          o_pc_write   = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b01;
        end
        S_MEM_ADR: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
        end
        S_MEM_READ: begin
          o_mem_req = 1'b1;
          o_adr_src = 1'b1;
        end
        S_MEM_WRITE: begin
          o_mem_req   = 1'b1;
          o_adr_src   = 1'b1;
          o_mem_write = 1'b1;
        end
        S_MEM_WB: begin
          o_result_src = 2'b01;
          o_reg_write  = 1'b1;
        end
        S_EXEC_R: begin
          o_alu_src_a   = 2'b10;
          o_alu_control = w_alu_op;
        end
        S_EXEC_I: begin
          o_alu_src_a   = 2'b10;
          o_alu_src_b   = 2'b01;
          o_alu_control = w_alu_op;
        end
        S_MULDIV: begin
          o_alu_src_a = 2'b10;
          o_md_start  = r_wait == 8'd0;
        end
        S_ALU_WB: begin
          o_result_src = r_from_md ? 2'b11 : 2'b00;
          o_reg_write  = 1'b1;
        end
        // target PC+imm already sits in the ALU output register; ALU forms old PC+4 for rd
        S_JAL: begin
          o_alu_src_b = 2'b10;
          o_pc_write  = 1'b1;
        end
        S_JALR: begin
          o_alu_src_a  = 2'b10;
          o_alu_src_b  = 2'b01;
          o_result_src = 2'b10;
          o_pc_write   = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a   = 2'b10;
          o_alu_control = 4'b0001;
          o_pc_write    = w_take && !w_f3_bad;
        end
        S_LUI: begin
          o_alu_src_a = 2'b11;
          o_alu_src_b = 2'b01;
        end
        S_AUIPC: o_alu_src_b = 2'b01;
        S_TRAP:  o_trap      = 1'b1;
        default: ;
      endcase
    end
  end
  assign o_trap_cause    = r_cause;
  assign o_retired_count = r_retired;
endmodule

// File: tb/tb_control_unit_mc2.sv
// tb_control_unit_mc2: directed self-checking bench for control_unit_mc2 (default build and a no-muldiv, 3-bit-counter build)
module tb_control_unit_mc2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, lt = 1'b0, slt = 1'b0, md_done = 1'b0;
  logic mr_a = 1'b0, mr_b = 1'b0, ta_a = 1'b0, ta_b = 1'b0;
  logic a_pc_write, a_reg_write, a_mem_write, a_ir_write, a_mem_req, a_adr_src, a_md_start, a_trap;
  logic [1:0] a_src_a, a_src_b, a_res, a_cause;
  logic [3:0] a_alu;
  logic [2:0] a_imm;
  logic [31:0] a_ret;
  logic b_pc_write, b_reg_write, b_mem_write, b_ir_write, b_mem_req, b_adr_src, b_md_start, b_trap;
  logic [1:0] b_src_a, b_src_b, b_res, b_cause;
  logic [3:0] b_alu;
  logic [2:0] b_imm;
  logic [2:0] b_ret;
  int n_chk = 0, n_err = 0, n_ret = 0, cnt_a = 0, cnt_b = 0;

  always #5 clk = ~clk;

  control_unit_mc2 u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_zero(zero), .i_less_than(lt), .i_signed_less_than(slt), .i_mem_ready(mr_a),
    .i_md_done(md_done), .i_trap_ack(ta_a), .o_pc_write(a_pc_write), .o_reg_write(a_reg_write),
    .o_mem_write(a_mem_write), .o_ir_write(a_ir_write), .o_mem_req(a_mem_req), .o_adr_src(a_adr_src),
    .o_alu_src_a(a_src_a), .o_alu_src_b(a_src_b), .o_result_src(a_res), .o_alu_control(a_alu),
    .o_imm_src(a_imm), .o_md_start(a_md_start), .o_trap(a_trap), .o_trap_cause(a_cause),
    .o_retired_count(a_ret)
  );

  control_unit_mc2 #(.ENABLE_MULDIV(1'b0), .MEM_TIMEOUT(4), .CNT_W(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_zero(zero), .i_less_than(lt), .i_signed_less_than(slt), .i_mem_ready(mr_b),
    .i_md_done(md_done), .i_trap_ack(ta_b), .o_pc_write(b_pc_write), .o_reg_write(b_reg_write),
    .o_mem_write(b_mem_write), .o_ir_write(b_ir_write), .o_mem_req(b_mem_req), .o_adr_src(b_adr_src),
    .o_alu_src_a(b_src_a), .o_alu_src_b(b_src_b), .o_result_src(b_res), .o_alu_control(b_alu),
    .o_imm_src(b_imm), .o_md_start(b_md_start), .o_trap(b_trap), .o_trap_cause(b_cause),
    .o_retired_count(b_ret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_a(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    mr_a = 1'b1;
    tick();
    mr_a = 1'b0;
  endtask

  task automatic retire_a;
    tick();
    n_ret++;
    #1 chk("retired", a_ret, 32'(n_ret));
  endtask

  task automatic alu_run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input int exp);
    fetch_a(op, f3, f7);
    tick();
    #1 chk("alu_ctl", 32'(a_alu), 32'(exp));
    tick();
    retire_a();
  endtask

  task automatic br_run(input logic [2:0] f3, input logic z, input logic l, input logic s, input int exp);
    zero = z;
    lt = l;
    slt = s;
    fetch_a(7'b1100011, f3, 7'd0);
    tick();
    #1 chk("br_pc_write", 32'(a_pc_write), 32'(exp));
    chk("br_alu_sub", 32'(a_alu), 1);
    retire_a();
  endtask

  initial begin
    opcode = 7'b0010011;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(a_mem_req), 0);
    chk("rst_pc_write", 32'(a_pc_write), 0);
    chk("rst_src_a", 32'(a_src_a), 0);
    chk("rst_retired", a_ret, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mr_a = (i == 3);
      #1;
      cnt_a += int'(a_mem_req);
      cnt_b += int'(a_ir_write && a_pc_write);
      tick();
    end
    mr_a = 1'b0;
    #1 chk("fetch_req_cycles", 32'(cnt_a), 4);
    chk("fetch_ir_pulses", 32'(cnt_b), 1);
    chk("decode_req", 32'(a_mem_req), 0);
    chk("decode_src_b", 32'(a_src_b), 1);
    tick();
    #1 chk("execi_src_a", 32'(a_src_a), 2);
    chk("execi_src_b", 32'(a_src_b), 1);
    tick();
    #1 chk("wb_reg_write", 32'(a_reg_write), 1);
    chk("wb_result_src", 32'(a_res), 0);
    retire_a();
    chk("fetch_again_req", 32'(a_mem_req), 1);

    alu_run(7'b0010011, 3'b101, 7'b0100000, 'b0111);
    alu_run(7'b0010011, 3'b101, 7'b0000000, 'b0110);
    alu_run(7'b0010011, 3'b000, 7'b0100000, 'b0000);
    alu_run(7'b0110011, 3'b000, 7'b0100000, 'b0001);
    alu_run(7'b0110011, 3'b000, 7'b0000000, 'b0000);
    alu_run(7'b0110011, 3'b011, 7'b0000000, 'b1001);
    alu_run(7'b0110011, 3'b010, 7'b0000000, 'b0101);
    alu_run(7'b0110011, 3'b001, 7'b0000000, 'b1000);
    alu_run(7'b0110011, 3'b111, 7'b0000000, 'b0010);
    alu_run(7'b0110011, 3'b110, 7'b0000000, 'b0011);
    alu_run(7'b0110011, 3'b100, 7'b0000000, 'b0100);

    br_run(3'b111, 1'b0, 1'b1, 1'b0, 0);
    br_run(3'b001, 1'b0, 1'b0, 1'b0, 1);
    br_run(3'b000, 1'b0, 1'b0, 1'b0, 0);
    br_run(3'b000, 1'b1, 1'b0, 1'b0, 1);
    br_run(3'b100, 1'b0, 1'b0, 1'b1, 1);
    br_run(3'b101, 1'b0, 1'b0, 1'b1, 0);
    br_run(3'b110, 1'b0, 1'b1, 1'b0, 1);
    zero = 1'b1;
    fetch_a(7'b1100011, 3'b010, 7'd0);
    tick();
    #1 chk("br_bad_pc_write", 32'(a_pc_write), 0);
    tick();
    #1 chk("br_bad_trap", 32'(a_trap), 1);
    chk("br_bad_cause", 32'(a_cause), 1);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    #1 chk("br_bad_ack_cause", 32'(a_cause), 0);
    chk("br_bad_retired", a_ret, 32'(n_ret));
    zero = 1'b0;

    fetch_a(7'b0110011, 3'b000, 7'b0000001);
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      md_done = (i == 7);
      #1 cnt_a += int'(a_md_start);
      if (i == 0) chk("md_start_first", 32'(a_md_start), 1);
    end
    tick();
    md_done = 1'b0;
    #1 chk("md_start_count", 32'(cnt_a), 1);
    chk("md_wb_reg_write", 32'(a_reg_write), 1);
    chk("md_wb_result_src", 32'(a_res), 3);
    retire_a();

    fetch_a(7'b0000011, 3'b010, 7'd0);
    tick();
    #1 chk("memadr_src_a", 32'(a_src_a), 2);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      #1 cnt_a += int'(a_mem_req && a_adr_src);
      cnt_b += int'(a_trap);
    end
    tick();
    #1 chk("to_req_cycles", 32'(cnt_a), 16);
    chk("to_early_trap", 32'(cnt_b), 0);
    chk("to_trap", 32'(a_trap), 1);
    chk("to_cause", 32'(a_cause), 2);
    chk("to_reg_write", 32'(a_reg_write), 0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    #1 chk("to_ack_req", 32'(a_mem_req), 1);
    chk("to_ack_cause", 32'(a_cause), 0);
    chk("to_retired", a_ret, 32'(n_ret));

    fetch_a(7'b0000011, 3'b010, 7'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      mr_a = (i == 15);
    end
    tick();
    mr_a = 1'b0;
    #1 chk("late_ready_trap", 32'(a_trap), 0);
    chk("memwb_reg_write", 32'(a_reg_write), 1);
    chk("memwb_result_src", 32'(a_res), 1);
    retire_a();

    fetch_a(7'b0100011, 3'b010, 7'd0);
    tick();
    tick();
    #1 chk("store_mem_write", 32'(a_mem_write), 1);
    chk("store_adr_src", 32'(a_adr_src), 1);
    chk("store_imm_src", 32'(a_imm), 1);
    mr_a = 1'b1;
    tick();
    mr_a = 1'b0;
    n_ret++;
    #1 chk("store_retired", a_ret, 32'(n_ret));

    fetch_a(7'b1101111, 3'b000, 7'd0);
    tick();
    #1 chk("jal_pc_write", 32'(a_pc_write), 1);
    chk("jal_imm_src", 32'(a_imm), 3);
    tick();
    #1 chk("jal_wb_reg_write", 32'(a_reg_write), 1);
    retire_a();

    fetch_a(7'b0110111, 3'b000, 7'd0);
    tick();
    #1 chk("lui_src_a", 32'(a_src_a), 3);
    chk("lui_imm_src", 32'(a_imm), 4);
    tick();
    retire_a();

    fetch_a(7'b0000000, 3'b000, 7'd0);
    tick();
    #1 chk("illegal_trap", 32'(a_trap), 1);
    chk("illegal_cause", 32'(a_cause), 1);
    chk("illegal_reg_write", 32'(a_reg_write), 0);
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    #1 chk("illegal_retired", a_ret, 32'(n_ret));

    fetch_a(7'b0100011, 3'b010, 7'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1 chk("midrst_mem_write", 32'(a_mem_write), 0);
    chk("midrst_mem_req", 32'(a_mem_req), 0);
    chk("midrst_retired", a_ret, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_req_a", 32'(a_mem_req), 1);
    chk("post_rst_req_b", 32'(b_mem_req), 1);

    opcode = 7'b0010011;
    funct3 = 3'b000;
    funct7 = 7'd0;
    repeat (3) tick();
    #1 chk("b_no_early_trap", 32'(b_trap), 0);
    tick();
    #1 chk("b_to_trap", 32'(b_trap), 1);
    chk("b_to_cause", 32'(b_cause), 2);
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    #1 chk("b_ack_retired", 32'(b_ret), 0);

    opcode = 7'b0110011;
    funct7 = 7'b0000001;
    mr_b = 1'b1;
    tick();
    mr_b = 1'b0;
    tick();
    #1 chk("b_mul_trap", 32'(b_trap), 1);
    chk("b_mul_cause", 32'(b_cause), 1);
    chk("b_mul_reg_write", 32'(b_reg_write), 0);
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;

    opcode = 7'b0010011;
    funct7 = 7'd0;
    for (int k = 1; k <= 8; k++) begin
      mr_b = 1'b1;
      tick();
      mr_b = 1'b0;
      repeat (3) tick();
      #1 chk("b_wrap_count", 32'(b_ret), 32'(k % 8));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
